exc_ctrl: RTL and testbench

- MEM-stage exception initiator that drives the CP0 register block's exception inputs: excepttype, current instruction address, delay-slot flag and bad address.
- Collects per-instruction exception flags, forwards in-flight MTC0 writes over the stale CP0 status/cause/epc values, and detects pending interrupts.
- Prioritises exceptions, then issues a registered flush with the redirect PC (handler vector or EPC for ERET) to the fetch stage.
- Also synchronises the external interrupt lines that feed CP0 cause[15:10].

---
 rtl/exc_ctrl_pkg.sv | 32 +++
 rtl/exc_int_sync.sv | 32 +++
 rtl/exc_ctrl.sv | 150 +++++++++++++++
 tb/tb_exc_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared excepttype codes, CP0 register numbers and exception flag indices
package exc_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } exc_state_e;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int FL_FETCH_ADEL = 0;
    localparam int FL_RI         = 1;
    localparam int FL_SYSCALL    = 2;
    localparam int FL_BREAK      = 3;
    localparam int FL_OVERFLOW   = 4;
    localparam int FL_TRAP       = 5;
    localparam int FL_DATA_ADEL  = 6;
    localparam int FL_DATA_ADES  = 7;

endpackage

// File: rtl/exc_int_sync.sv
// exc_int_sync: SYNC_STAGES-deep flop chain bringing the async interrupt lines into clk
//   clk, rst    : clock, synchronous active-high reset (clears every stage)
//   int_i       : asynchronous interrupt lines
//   int_sync_o  : int_i delayed by SYNC_STAGES cycles
module exc_int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] int_i,
    output logic [5:0] int_sync_o
);

    logic [5:0] sync_q [SYNC_STAGES];
    logic [5:0] sync_d [SYNC_STAGES];

    always_comb begin
        sync_d[0] = int_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign int_sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception initiator driving CP0 exception inputs and the pipeline flush
//   clk, rst                 : clock, synchronous active-high reset
//   int_i / int_sync_o       : raw interrupt lines / synchronised copy for CP0 cause[15:10]
//   mem_*                    : MEM-stage instruction: valid, pc, delay slot, flags, eret, bad addresses
//   stall_i                  : pipeline stall, blocks acceptance
//   cp0_status/cause/epc_i   : committed CP0 state
//   wb_cp0_we/waddr/wdata_i  : in-flight WB-stage MTC0, forwarded over the committed state
//   excepttype_o, exc_pc_o,
//   exc_delayslot_o, bad_addr_o : one-cycle exception record for CP0
//   flush_o, new_pc_o        : one-cycle pipeline flush and redirect target
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    output logic [5:0]  int_sync_o,
    input  logic        mem_valid_i,
    input  logic        stall_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [7:0]  mem_exc_i,
    input  logic        mem_eret_i,
    input  logic [31:0] mem_fetch_badaddr_i,
    input  logic [31:0] mem_data_badaddr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    exc_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
        .clk        (clk),
        .rst        (rst),
        .int_i      (int_i),
        .int_sync_o (int_sync_o)
    );

    exc_state_e  state_q, state_d;
    logic [31:0] excepttype_q, excepttype_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        exc_delayslot_q, exc_delayslot_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic [31:0] eff_status, eff_cause, eff_epc;
    logic        int_pending;
    logic [31:0] code, bad_sel;
    logic        accept;

    // Only the IE/EXL/IM fields of status and the IP field of cause matter here.
    logic unused_bits;
    assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

    always_comb begin
        eff_status = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) ? wb_cp0_wdata_i : cp0_status_i;
        eff_epc    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC) ? wb_cp0_wdata_i : cp0_epc_i;
        eff_cause  = cp0_cause_i;
        // Only the software-interrupt bits of cause are writable by MTC0.
        if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE) eff_cause[9:8] = wb_cp0_wdata_i[9:8];
        int_pending = eff_status[0] && !eff_status[1] && |(eff_cause[15:8] & eff_status[15:8]);
        code    = '0;
        bad_sel = '0;
        if (int_pending) begin
            code = EXC_INT;
        end else if (mem_exc_i[FL_FETCH_ADEL]) begin
            code    = EXC_ADEL;
            bad_sel = mem_fetch_badaddr_i;
        end else if (mem_exc_i[FL_RI]) begin
            code = EXC_RI;
        end else if (mem_exc_i[FL_SYSCALL]) begin
            code = EXC_SYS;
        end else if (mem_exc_i[FL_BREAK]) begin
            code = EXC_BP;
        end else if (mem_exc_i[FL_OVERFLOW]) begin
            code = EXC_OV;
        end else if (mem_exc_i[FL_TRAP]) begin
            code = EXC_TR;
        end else if (mem_exc_i[FL_DATA_ADEL]) begin
            code    = EXC_ADEL;
            bad_sel = mem_data_badaddr_i;
        end else if (mem_exc_i[FL_DATA_ADES]) begin
            code    = EXC_ADES;
            bad_sel = mem_data_badaddr_i;
        end else if (mem_eret_i) begin
            code = EXC_ERET;
        end
    end

    always_comb begin
        accept          = state_q == ST_IDLE && mem_valid_i && !stall_i && code != '0;
        state_d         = ST_IDLE;
        excepttype_d    = '0;
        exc_pc_d        = '0;
        exc_delayslot_d = 1'b0;
        bad_addr_d      = '0;
        flush_d         = 1'b0;
        new_pc_d        = '0;
        // FLUSH always falls back to IDLE with a zeroed record, so each report is a single pulse.
        if (accept) begin
            state_d         = ST_FLUSH;
            excepttype_d    = code;
            exc_pc_d        = mem_pc_i;
            exc_delayslot_d = mem_in_delayslot_i;
            bad_addr_d      = bad_sel;
            flush_d         = 1'b1;
            new_pc_d        = (code == EXC_ERET) ? eff_epc : EXC_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            excepttype_q    <= '0;
            exc_pc_q        <= '0;
            exc_delayslot_q <= 1'b0;
            bad_addr_q      <= '0;
            flush_q         <= 1'b0;
            new_pc_q        <= '0;
        end else begin
            state_q         <= state_d;
            excepttype_q    <= excepttype_d;
            exc_pc_q        <= exc_pc_d;
            exc_delayslot_q <= exc_delayslot_d;
            bad_addr_q      <= bad_addr_d;
            flush_q         <= flush_d;
            new_pc_q        <= new_pc_d;
        end
    end

    assign excepttype_o    = excepttype_q;
    assign exc_pc_o        = exc_pc_q;
    assign exc_delayslot_o = exc_delayslot_q;
    assign bad_addr_o      = bad_addr_q;
    assign flush_o         = flush_q;
    assign new_pc_o        = new_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed scenarios plus randomized traffic checked against a reference model
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i, int_sync_o;
    logic        mem_valid_i, stall_i, mem_in_delayslot_i, mem_eret_i;
    logic [31:0] mem_pc_i, mem_fetch_badaddr_i, mem_data_badaddr_i;
    logic [7:0]  mem_exc_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_wdata_i;
    logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, new_pc_o;
    logic        exc_delayslot_o, flush_o;

    int checks = 0;
    int errors = 0;

    exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .int_i               (int_i),
        .int_sync_o          (int_sync_o),
        .mem_valid_i         (mem_valid_i),
        .stall_i             (stall_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_exc_i           (mem_exc_i),
        .mem_eret_i          (mem_eret_i),
        .mem_fetch_badaddr_i (mem_fetch_badaddr_i),
        .mem_data_badaddr_i  (mem_data_badaddr_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_wdata_i      (wb_cp0_wdata_i),
        .excepttype_o        (excepttype_o),
        .exc_pc_o            (exc_pc_o),
        .exc_delayslot_o     (exc_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o)
    );

    always #5 clk = ~clk;

    // Priority is simply ascending flag index; the table maps each flag to its excepttype.
    function automatic void model(output logic [31:0] code, output logic [31:0] bad, output logic [31:0] npc);
        logic [31:0] st, ca, ep;
        logic [31:0] tbl [8];
        tbl = '{32'h4, 32'ha, 32'h8, 32'h9, 32'hc, 32'hd, 32'h4, 32'h5};
        st = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_wdata_i : cp0_status_i;
        ep = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_wdata_i : cp0_epc_i;
        ca = cp0_cause_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_wdata_i[9:8];
        code = 0;
        bad  = 0;
        npc  = VEC;
        if (st[0] && !st[1] && (ca[15:8] & st[15:8]) != 0) begin
            code = 1;
        end else begin
            for (int b = 7; b >= 0; b--)
                if (mem_exc_i[b]) begin
                    code = tbl[b];
                    bad  = (b == 0) ? mem_fetch_badaddr_i : (b >= 6) ? mem_data_badaddr_i : 32'h0;
                end
            if (code == 0 && mem_eret_i) begin
                code = 32'he;
                npc  = ep;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        int_i = 0; mem_valid_i = 0; stall_i = 0; mem_pc_i = 0; mem_in_delayslot_i = 0;
        mem_exc_i = 0; mem_eret_i = 0; mem_fetch_badaddr_i = 0; mem_data_badaddr_i = 0;
        cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
        wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_wdata_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        int_i = 6'h3f; mem_valid_i = 1; mem_exc_i = 8'h04; mem_pc_i = 32'h1234;
        step(); step(); step();
        checks++;
        if ({excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o, flush_o, new_pc_o, int_sync_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got et=%h pc=%h ds=%b bad=%h fl=%b npc=%h sync=%h required all 0",
                     excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o, flush_o, new_pc_o, int_sync_o);
        end
        clear_inputs();
        rst = 0;
        step(); step();
    endtask

    task automatic test_syscall();
        clear_inputs();
        mem_valid_i = 1; mem_exc_i = 8'h04; mem_pc_i = 32'hBFC01000;
        step();
        checks++;
        if ({excepttype_o, exc_pc_o, flush_o, new_pc_o} !== {32'h8, 32'hBFC01000, 1'b1, VEC}) begin
            errors++;
            $display("FAIL syscall: got et=%h pc=%h fl=%b npc=%h required et=8 pc=bfc01000 fl=1 npc=%h",
                     excepttype_o, exc_pc_o, flush_o, new_pc_o, VEC);
        end
        clear_inputs();
        step();
        checks++;
        if ({excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o, flush_o, new_pc_o} !== '0) begin
            errors++;
            $display("FAIL syscall_pulse_end: got et=%h pc=%h fl=%b npc=%h required all 0",
                     excepttype_o, exc_pc_o, flush_o, new_pc_o);
        end
    endtask

    task automatic test_eret_fwd();
        clear_inputs();
        mem_valid_i = 1; mem_eret_i = 1; cp0_epc_i = 32'h100;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'hBFC02000;
        step();
        checks++;
        if ({excepttype_o, new_pc_o, flush_o} !== {32'he, 32'hBFC02000, 1'b1}) begin
            errors++;
            $display("FAIL eret_fwd: got et=%h npc=%h fl=%b required et=e npc=bfc02000 fl=1",
                     excepttype_o, new_pc_o, flush_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_int_priority();
        clear_inputs();
        mem_valid_i = 1; cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h400; mem_exc_i = 8'h02;
        step();
        checks++;
        if ({excepttype_o, flush_o} !== {32'h1, 1'b1}) begin
            errors++;
            $display("FAIL int_priority: got et=%h fl=%b required et=1 fl=1", excepttype_o, flush_o);
        end
        clear_inputs();
        step();
        // IP0 raised only by the forwarded MTC0 to cause
        mem_valid_i = 1; cp0_status_i = 32'h0000_0101;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_wdata_i = 32'h0000_0100;
        step();
        checks++;
        if (excepttype_o !== 32'h1) begin
            errors++;
            $display("FAIL int_cause_fwd: got et=%h required 1", excepttype_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_int_mask();
        clear_inputs();
        mem_valid_i = 1; cp0_status_i = 32'h0000FF03; cp0_cause_i = 32'h400;
        step();
        checks++;
        if ({excepttype_o, flush_o} !== '0) begin
            errors++;
            $display("FAIL int_mask_exl: got et=%h fl=%b required 0", excepttype_o, flush_o);
        end
        // IE cleared by a forwarded status write
        cp0_status_i = 32'h0000FF01;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_wdata_i = 32'h0000FF00;
        step();
        checks++;
        if ({excepttype_o, flush_o} !== '0) begin
            errors++;
            $display("FAIL int_mask_fwd: got et=%h fl=%b required 0", excepttype_o, flush_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_ades();
        clear_inputs();
        mem_valid_i = 1; mem_exc_i = 8'h80; mem_data_badaddr_i = 32'h80000003;
        mem_in_delayslot_i = 1; mem_pc_i = 32'h8000_0040; mem_fetch_badaddr_i = 32'hdead0000;
        step();
        checks++;
        if ({excepttype_o, bad_addr_o, exc_delayslot_o, exc_pc_o} !== {32'h5, 32'h80000003, 1'b1, 32'h8000_0040}) begin
            errors++;
            $display("FAIL data_ades: got et=%h bad=%h ds=%b pc=%h required et=5 bad=80000003 ds=1 pc=80000040",
                     excepttype_o, bad_addr_o, exc_delayslot_o, exc_pc_o);
        end
        clear_inputs();
        mem_valid_i = 1; mem_exc_i = 8'h41; mem_fetch_badaddr_i = 32'h0000_0002; mem_data_badaddr_i = 32'h5;
        step();
        checks++;
        if ({excepttype_o, flush_o} !== '0) begin
            errors++;
            $display("FAIL flush_ignores_input: got et=%h fl=%b required 0", excepttype_o, flush_o);
        end
        step();
        checks++;
        if ({excepttype_o, bad_addr_o} !== {32'h4, 32'h2}) begin
            errors++;
            $display("FAIL fetch_adel: got et=%h bad=%h required et=4 bad=2", excepttype_o, bad_addr_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_stall_back_to_back();
        clear_inputs();
        mem_valid_i = 1; mem_exc_i = 8'h04; mem_pc_i = 32'h80001000; stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({excepttype_o, flush_o} !== '0) begin
                errors++;
                $display("FAIL stall_no_flush[%0d]: got et=%h fl=%b required 0", i, excepttype_o, flush_o);
            end
        end
        stall_i = 0;
        step();
        checks++;
        if ({excepttype_o, flush_o, exc_pc_o} !== {32'h8, 1'b1, 32'h80001000}) begin
            errors++;
            $display("FAIL stall_release: got et=%h fl=%b pc=%h required et=8 fl=1 pc=80001000",
                     excepttype_o, flush_o, exc_pc_o);
        end
        mem_exc_i = 8'h08;
        step();
        checks++;
        if ({excepttype_o, flush_o} !== '0) begin
            errors++;
            $display("FAIL back_to_back: got et=%h fl=%b required 0", excepttype_o, flush_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_rst_mid_flush();
        clear_inputs();
        mem_valid_i = 1; mem_exc_i = 8'h10; mem_pc_i = 32'h4;
        step();
        checks++;
        if (flush_o !== 1'b1 || excepttype_o !== 32'hc) begin
            errors++;
            $display("FAIL overflow: got et=%h fl=%b required et=c fl=1", excepttype_o, flush_o);
        end
        rst = 1;
        step();
        checks++;
        if ({excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o, flush_o, new_pc_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid_flush: got et=%h fl=%b required 0", excepttype_o, flush_o);
        end
        rst = 0;
        mem_exc_i = 8'h20;
        step();
        checks++;
        if ({excepttype_o, flush_o} !== {32'hd, 1'b1}) begin
            errors++;
            $display("FAIL after_rst_accept: got et=%h fl=%b required et=d fl=1", excepttype_o, flush_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_sync();
        clear_inputs();
        step(); step();
        int_i = 6'h2a;
        step();
        checks++;
        if (int_sync_o !== 6'h00) begin
            errors++;
            $display("FAIL sync_early: got %h required 00", int_sync_o);
        end
        int_i = 6'h15;
        step();
        checks++;
        if (int_sync_o !== 6'h2a) begin
            errors++;
            $display("FAIL sync_2cyc: got %h required 2a", int_sync_o);
        end
        step();
        checks++;
        if (int_sync_o !== 6'h15) begin
            errors++;
            $display("FAIL sync_toggle: got %h required 15", int_sync_o);
        end
        int_i = 0;
        step(); step();
    endtask

    task automatic test_random();
        logic [31:0] c, b, n;
        logic        busy, acc;
        logic [5:0]  prev_int;
        logic [128:0] exp_v, got_v;
        logic [4:0]  regs [4];
        regs = '{5'd12, 5'd13, 5'd14, 5'd9};
        busy = 0;
        prev_int = int_i;
        for (int k = 0; k < 600; k++) begin
            int_i               = 6'($urandom);
            mem_valid_i         = ($urandom_range(0, 7) != 0);
            stall_i             = ($urandom_range(0, 3) == 0);
            mem_pc_i            = $urandom;
            mem_in_delayslot_i  = 1'($urandom);
            mem_exc_i           = 8'($urandom & $urandom & $urandom);
            mem_eret_i          = ($urandom_range(0, 3) == 0);
            mem_fetch_badaddr_i = $urandom;
            mem_data_badaddr_i  = $urandom;
            cp0_status_i        = $urandom & 32'h0000_FF03;
            cp0_cause_i         = $urandom & $urandom & 32'h0000_FF00;
            cp0_epc_i           = $urandom;
            wb_cp0_we_i         = ($urandom_range(0, 2) == 0);
            wb_cp0_waddr_i      = regs[$urandom_range(0, 3)];
            wb_cp0_wdata_i      = $urandom;
            model(c, b, n);
            acc = !busy && mem_valid_i && !stall_i && c != 0;
            exp_v = acc ? {c, mem_pc_i, mem_in_delayslot_i, b, 1'b1, n} : '0;
            step();
            got_v = {excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o, flush_o, new_pc_o};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: got {et,pc,ds,bad,fl,npc}=%h required %h", k, got_v, exp_v);
            end
            checks++;
            if (int_sync_o !== prev_int) begin
                errors++;
                $display("FAIL random_sync[%0d]: got %h required %h", k, int_sync_o, prev_int);
            end
            prev_int = int_i;
            busy = acc;
        end
        clear_inputs();
        step(); step();
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_eret_fwd();
        test_int_priority();
        test_int_mask();
        test_ades();
        test_stall_back_to_back();
        test_rst_mid_flush();
        test_sync();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
